// File: rtl/instruction_cache_ctrl.sv
// instruction_cache_ctrl
//   Direct-mapped, read-only instruction cache sitting between the PC and the
//   instruction memory in the IF stage. Hits return the word combinationally;
//   misses raise busyWait (freezing the PC) and fill one 128-bit block from
//   instruction memory over a read/busywait handshake.
//
//   Geometry: 4-word blocks, offset = address[3:2], index = address[3+INDEX_W:4],
//   tag = address[31:4+INDEX_W]. address[1:0] is ignored.
//
// Ports
//   CLK          in   clock, all state updates on posedge
//   RESET        in   synchronous, active-high; clears valid bits and aborts a fill
//   address      in   fetch address from PC
//   read_en      in   fetch request valid
//   instruction  out  fetched word, valid when read_en & !busyWait
//   busyWait     out  stall to PC
//   mem_read     out  block read request to instruction memory
//   mem_address  out  block address address[31:4] of the pending miss
//   mem_readdata in   block data, word0 in [31:0]
//   mem_busywait in   memory busy; data valid when low while mem_read is high
//   hit_count    out  (ICACHE_STATS_EN only) IDLE cycles with read_en & hit
//   miss_count   out  (ICACHE_STATS_EN only) IDLE -> MEM_READ transitions
//
// Configuration macro: ICACHE_STATS_EN adds the hit/miss counters and ports.

module instruction_cache_ctrl #(
  parameter int unsigned INDEX_W = 3
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic [31:0]   address,
  input  logic          read_en,
  output logic [31:0]   instruction,
  output logic          busyWait,
  output logic          mem_read,
  output logic [27:0]   mem_address,
  input  logic [127:0]  mem_readdata,
  input  logic          mem_busywait
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]   hit_count,
  output logic [31:0]   miss_count
`endif
);

  localparam int unsigned Lines = 2 ** INDEX_W;
  localparam int unsigned TagW  = 28 - INDEX_W;

  typedef enum logic [1:0] {
    StIdle,
    StMemRead,
    StUpdate
  } state_e;

  state_e state_q, state_d;

  logic [Lines-1:0] valid_q;
  logic [TagW-1:0]  tag_q  [Lines];
  logic [127:0]     data_q [Lines];

  logic [27:0]  miss_blk_q;
  logic [127:0] fill_q;

  logic [INDEX_W-1:0] addr_idx;
  logic [TagW-1:0]    addr_tag;
  logic [1:0]         addr_off;
  logic [INDEX_W-1:0] upd_idx;
  logic [127:0]       line;
  logic               hit;
  logic               miss_start;

  logic unused_addr_bits;
  assign unused_addr_bits = ^address[1:0];

  assign addr_idx = address[3+INDEX_W:4];
  assign addr_tag = address[31:4+INDEX_W];
  assign addr_off = address[3:2];
  assign upd_idx  = miss_blk_q[INDEX_W-1:0];

  assign line = data_q[addr_idx];
  assign hit  = valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);

  always_comb begin
    instruction = line[31:0];
    unique case (addr_off)
      2'd0: instruction = line[31:0];
      2'd1: instruction = line[63:32];
      2'd2: instruction = line[95:64];
      2'd3: instruction = line[127:96];
    endcase
  end

  always_comb begin
    state_d     = state_q;
    busyWait    = 1'b0;
    mem_read    = 1'b0;
    mem_address = '0;
    miss_start  = 1'b0;
    case (state_q)
      StIdle: begin
        if (read_en && !hit) begin
          busyWait   = 1'b1;
          miss_start = 1'b1;
          state_d    = StMemRead;
        end
      end
      StMemRead: begin
        busyWait    = 1'b1;
        mem_read    = 1'b1;
        // Always the latched block, so a moving PC cannot corrupt the fill.
        mem_address = miss_blk_q;
        if (!mem_busywait) state_d = StUpdate;
      end
      StUpdate: begin
        busyWait = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= StIdle;
      valid_q    <= '0;
      miss_blk_q <= '0;
    end else begin
      state_q <= state_d;
      if (miss_start) miss_blk_q <= address[31:4];
      if (state_q == StUpdate) valid_q[upd_idx] <= 1'b1;
    end
  end

  // Tag/data storage is deliberately left uncleared by reset; valid bits guard it.
  always_ff @(posedge CLK) begin
    if (state_q == StMemRead && !mem_busywait) fill_q <= mem_readdata;
    if (!RESET && state_q == StUpdate) begin
      tag_q[upd_idx]  <= miss_blk_q[27:INDEX_W];
      data_q[upd_idx] <= fill_q;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (state_q == StIdle && read_en && hit) hit_cnt_q <= hit_cnt_q + 32'd1;
      if (miss_start) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_cache_ctrl.sv
// tb_instruction_cache_ctrl
//   Self-checking bench for instruction_cache_ctrl with a behavioural cache
//   model (per-index valid + block address) and a latency-programmable
//   instruction memory.

module tb_instruction_cache_ctrl;

  localparam int unsigned INDEX_W = 3;
  localparam int unsigned Lines   = 8;

  logic         CLK;
  logic         RESET;
  logic [31:0]  address;
  logic         read_en;
  logic [31:0]  instruction;
  logic         busyWait;
  logic         mem_read;
  logic [27:0]  mem_address;
  logic [127:0] mem_readdata;
  logic         mem_busywait;
`ifdef ICACHE_STATS_EN
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
`endif

  instruction_cache_ctrl #(.INDEX_W(INDEX_W)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .address      (address),
    .read_en      (read_en),
    .instruction  (instruction),
    .busyWait     (busyWait),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_readdata (mem_readdata),
    .mem_busywait (mem_busywait)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  // Instruction memory: completes in the mem_lat-th cycle of mem_read.
  int unsigned mem_lat = 1;
  int unsigned mem_cnt = 0;

  always @(posedge CLK) mem_cnt <= mem_read ? mem_cnt + 1 : 0;
  assign mem_busywait = mem_read && (mem_cnt + 1 < mem_lat);

  function automatic logic [31:0] mem_word(input logic [27:0] blk, input logic [1:0] w);
    logic [31:0] x;
    if (blk == 28'h0 && w == 2'd0) return 32'h00500093;
    x = ({4'h0, blk} << 2) + {30'b0, w} + 32'd1;
    return (x * 32'h9E3779B1) ^ 32'hA5A50000;
  endfunction

  always_comb mem_readdata = {mem_word(mem_address, 2'd3), mem_word(mem_address, 2'd2),
                              mem_word(mem_address, 2'd1), mem_word(mem_address, 2'd0)};

  // Reference model: which block each index holds, plus expected statistics.
  bit          mv   [Lines];
  logic [27:0] mblk [Lines];
  int unsigned exp_hits = 0;
  int unsigned exp_misses = 0;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    foreach (mv[i]) mv[i] = 1'b0;
    exp_hits   = 0;
    exp_misses = 0;
  endtask

  // Reset for one edge; outputs are checked right after that edge.
  task automatic do_reset(input logic ren);
    read_en = ren;
    RESET   = 1'b1;
    @(posedge CLK); #1;
    model_clear();
    check32("rst_mem_read", 32'(mem_read), 32'd0);
    check32("rst_mem_address", 32'(mem_address), 32'd0);
    check32("rst_busy", 32'(busyWait), 32'(ren));
    RESET   = 1'b0;
    read_en = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic idle_cycle();
    read_en = 1'b0;
    address = $urandom;
    @(negedge CLK);
    check32("idle_busy", 32'(busyWait), 32'd0);
    check32("idle_mem_read", 32'(mem_read), 32'd0);
    @(posedge CLK); #1;
  endtask

  task automatic fetch(input logic [31:0] a);
    int          idx;
    logic [27:0] blk;
    int          cyc;
    int          rd;
    idx     = int'(a[6:4]);
    blk     = a[31:4];
    address = a;
    read_en = 1'b1;
    @(negedge CLK);
    if (mv[idx] && mblk[idx] == blk) begin
      check32("hit_busy", 32'(busyWait), 32'd0);
      check32("hit_instr", instruction, mem_word(blk, a[3:2]));
      check32("hit_mem_read", 32'(mem_read), 32'd0);
      exp_hits++;
    end else begin
      check32("miss_busy", 32'(busyWait), 32'd1);
      cyc = 1;
      rd  = 0;
      while (busyWait && cyc < 40) begin
        @(posedge CLK);
        @(negedge CLK);
        if (busyWait) begin
          cyc++;
          if (mem_read) begin
            rd++;
            check32("miss_mem_address", 32'(mem_address), 32'(blk));
          end
        end
      end
      check32("miss_latency", 32'(cyc), 32'(mem_lat + 2));
      check32("miss_read_cycles", 32'(rd), 32'(mem_lat));
      check32("refill_instr", instruction, mem_word(blk, a[3:2]));
      mv[idx]   = 1'b1;
      mblk[idx] = blk;
      exp_misses++;
      exp_hits++;
    end
    @(posedge CLK); #1;
  endtask

  task automatic check_stats();
`ifdef ICACHE_STATS_EN
    read_en = 1'b0;
    @(negedge CLK);
    check32("hit_count", hit_count, 32'(exp_hits));
    check32("miss_count", miss_count, 32'(exp_misses));
    @(posedge CLK); #1;
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    RESET   = 1'b1;
    read_en = 1'b1;
    address = 32'h0;
    model_clear();

    // Cold miss on block 0, then a hit on word1 of the same block.
    do_reset(1'b1);
    mem_lat = 3;
    fetch(32'h0000_0000);
    fetch(32'h0000_0004);
    check_stats();

    // Conflict miss on index 0, then the original block misses again.
    mem_lat = 2;
    fetch(32'h0000_0080);
    fetch(32'h0000_0000);
    fetch(32'h0000_0088);

    // Reset during the second MEM_READ cycle aborts the fill.
    do_reset(1'b0);
    mem_lat = 5;
    address = 32'h0;
    read_en = 1'b1;
    @(negedge CLK);
    check32("abort_miss_busy", 32'(busyWait), 32'd1);
    @(posedge CLK);
    @(posedge CLK); #1;
    check32("abort_in_mem_read", 32'(mem_read), 32'd1);
    RESET = 1'b1;
    @(posedge CLK); #1;
    model_clear();
    check32("abort_mem_read", 32'(mem_read), 32'd0);
    check32("abort_busy", 32'(busyWait), 32'd1);
    RESET   = 1'b0;
    read_en = 1'b0;
    @(posedge CLK); #1;
    fetch(32'h0000_0000);

    // Quiet period with no requests.
    do_reset(1'b0);
    for (int i = 0; i < 10; i++) idle_cycle();
    check_stats();

    // Random traffic over a small block set so hits and conflicts both occur.
    for (int i = 0; i < 80; i++) begin
      mem_lat = $urandom_range(1, 4);
      if ($urandom_range(0, 3) == 0) idle_cycle();
      a = ($urandom_range(0, 31) << 4) | $urandom_range(0, 15);
      if ($urandom_range(0, 7) == 0) a = $urandom;
      fetch(a);
    end
    check_stats();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
